mul_mdc_ctrl: RTL

MUL_MDC_CTRL -- requirements
Module: mul_mdc_ctrl

---
 rtl/mul_mdc_ctrl_if.sv | 20 ++
 rtl/mul_mdc_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/mul_mdc_ctrl_if.sv
// Job descriptor and completion streams between the host and the multiply job controller.
// The slave modport is the controller's view; master is the host side.
interface mul_mdc_ctrl_if;
  logic        cfg_TVALID;
  logic        cfg_TREADY;
  logic [31:0] cfg_TDATA;
  logic        done_TVALID;
  logic        done_TREADY;
  logic [15:0] done_TDATA;

  modport slave (
    input  cfg_TVALID, cfg_TDATA, done_TREADY,
    output cfg_TREADY, done_TVALID, done_TDATA
  );

  modport master (
    output cfg_TVALID, cfg_TDATA, done_TREADY,
    input  cfg_TREADY, done_TVALID, done_TDATA
  );
endinterface

// File: rtl/mul_mdc_ctrl.sv
// Job controller for the multiply engine: accepts one descriptor, gates len+1 a/b beats,
// waits for the expected d outputs, then reports the job index on the completion stream.
module mul_mdc_ctrl (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  mul_mdc_ctrl_if.slave         bus,
  output logic                  eng_reg_simple_mul,
  output logic [4:0]            eng_reg_shift,
  output logic [11:0]           eng_reg_len,
  output logic                  ab_en,
  input  logic                  ab_fire,
  input  logic                  d_fire,
  input  logic                  clear,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [12:0] ab_cnt, d_cnt;
  logic [12:0] len_p1, exp_d;
  logic [15:0] job_idx;
  logic        cfg_hs, done_hs;
  logic        ab_ok, ab_bad, d_win, d_ok, d_bad;
  logic        cfg_unused;

  // 13-bit beat targets so len=4095 (4096 beats) does not wrap.
  assign len_p1 = {1'b0, eng_reg_len} + 13'd1;
  assign exp_d  = eng_reg_simple_mul ? len_p1 : 13'd1;

  assign bus.cfg_TREADY  = (state == IDLE);
  assign bus.done_TVALID = (state == DONE);
  assign bus.done_TDATA  = job_idx;
  assign busy            = (state != IDLE);
  assign ab_en           = (state == RUN) && (ab_cnt < len_p1);

  assign cfg_hs     = bus.cfg_TVALID & bus.cfg_TREADY;
  assign done_hs    = bus.done_TVALID & bus.done_TREADY;
  assign cfg_unused = ^bus.cfg_TDATA[31:18];

  // Out-of-window pulses flag the error and are never counted.
  assign ab_ok  = ab_fire & ab_en;
  assign ab_bad = ab_fire & ~ab_en;
  assign d_win  = (state == RUN) || (state == DRAIN);
  assign d_ok   = d_fire & d_win & (d_cnt != exp_d);
  assign d_bad  = d_fire & ~d_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cfg_hs)             state_nxt = LOAD;
        LOAD:                            state_nxt = RUN;
        RUN:     if (ab_cnt == len_p1)   state_nxt = DRAIN;
        DRAIN:   if (d_cnt == exp_d)     state_nxt = DONE;
        DONE:    if (done_hs)            state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      eng_reg_simple_mul <= 1'b0;
      eng_reg_shift      <= '0;
      eng_reg_len        <= '0;
      ab_cnt             <= '0;
      d_cnt              <= '0;
      job_idx            <= '0;
      err                <= 1'b0;
    end else if (clear) begin
      // Soft clear keeps job_idx and the engine registers.
      ab_cnt <= '0;
      d_cnt  <= '0;
      err    <= 1'b0;
    end else begin
      if (cfg_hs) begin
        eng_reg_simple_mul <= bus.cfg_TDATA[0];
        eng_reg_shift      <= bus.cfg_TDATA[5:1];
        eng_reg_len        <= bus.cfg_TDATA[17:6];
        ab_cnt             <= '0;
        d_cnt              <= '0;
      end
      if (ab_ok)           ab_cnt  <= ab_cnt + 13'd1;
      if (d_ok)            d_cnt   <= d_cnt + 13'd1;
      if (ab_bad || d_bad) err     <= 1'b1;
      if (done_hs)         job_idx <= job_idx + 16'd1;
    end
  end

endmodule
